// File: rtl/ct_lsu_wmb_cmplt_queue.sv
// WMB completion queue: 4-entry FIFO of completion events presented to the ST WB arbiter.
// Optional same-cycle bypass of a push into an empty queue when CT_LSU_WMB_CQ_BYPASS_EN is defined.
module ct_lsu_wmb_cmplt_queue (
    input  logic       ctrl_st_clk,
    input  logic       cpurst_b,
    input  logic       rtu_yy_xx_flush,
    input  logic       wmb_cq_push_vld,
    input  logic [6:0] wmb_cq_push_iid,
    input  logic       wmb_cq_push_inst_flush,
    input  logic       wmb_cq_push_spec_fail,
    input  logic       wmb_cq_push_bkpta_data,
    input  logic       wmb_cq_push_bkptb_data,
    output logic       cq_wmb_full,
    output logic       cq_wmb_empty,
    output logic       wmb_st_wb_cmplt_req,
    output logic [6:0] wmb_st_wb_iid,
    output logic       wmb_st_wb_inst_flush,
    output logic       wmb_st_wb_spec_fail,
    output logic       wmb_st_wb_bkpta_data,
    output logic       wmb_st_wb_bkptb_data,
    input  logic       st_wb_wmb_cmplt_grnt
);

    logic [2:0]  r_rptr;
    logic [2:0]  r_wptr;
    logic [10:0] r_entry [0:3];

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_write;
    logic        w_req;
    logic [10:0] w_push_data;
    logic [10:0] w_head;

    assign w_push_data = {wmb_cq_push_iid, wmb_cq_push_inst_flush, wmb_cq_push_spec_fail,
                          wmb_cq_push_bkpta_data, wmb_cq_push_bkptb_data};

    // Full is derived from the current pointers only, so a same-cycle pop never frees a slot for a push.
    assign w_empty = (r_rptr == r_wptr);
    assign w_full  = (r_rptr[1:0] == r_wptr[1:0]) && (r_rptr[2] != r_wptr[2]);
    assign w_push  = wmb_cq_push_vld & ~w_full & ~rtu_yy_xx_flush;
    assign w_pop   = ~w_empty & st_wb_wmb_cmplt_grnt & ~rtu_yy_xx_flush;

`ifdef CT_LSU_WMB_CQ_BYPASS_EN
    logic w_bypass;

    // A granted bypass consumes the event directly, so it is never stored.
    assign w_bypass = w_push & w_empty;
    assign w_req    = ~w_empty | w_bypass;
    assign w_head   = w_bypass ? w_push_data : r_entry[r_rptr[1:0]];
    assign w_write  = w_push & ~(w_bypass & st_wb_wmb_cmplt_grnt);
`else
    assign w_req    = ~w_empty;
    assign w_head   = r_entry[r_rptr[1:0]];
    assign w_write  = w_push;
`endif

    always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_rptr <= 3'd0;
            r_wptr <= 3'd0;
        end else if (rtu_yy_xx_flush) begin
            r_rptr <= 3'd0;
            r_wptr <= 3'd0;
        end else begin
            if (w_write)
                r_wptr <= r_wptr + 3'd1;
            if (w_pop)
                r_rptr <= r_rptr + 3'd1;
        end
    end

    always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < 4; i++)
                r_entry[i] <= 11'd0;
        end else if (w_write) begin
            r_entry[r_wptr[1:0]] <= w_push_data;
        end
    end

    assign cq_wmb_full          = w_full;
    assign cq_wmb_empty         = w_empty;
    assign wmb_st_wb_cmplt_req  = w_req;
    assign wmb_st_wb_iid        = w_head[10:4];
    assign wmb_st_wb_inst_flush = w_head[3];
    assign wmb_st_wb_spec_fail  = w_head[2];
    assign wmb_st_wb_bkpta_data = w_head[1];
    assign wmb_st_wb_bkptb_data = w_head[0];

endmodule

// File: tb/tb_ct_lsu_wmb_cmplt_queue.sv
// Directed self-checking bench for ct_lsu_wmb_cmplt_queue; define CT_LSU_WMB_CQ_BYPASS_EN to cover the bypass build.
`timescale 1ns/1ps
module tb_ct_lsu_wmb_cmplt_queue;

    logic       ctrl_st_clk;
    logic       cpurst_b;
    logic       rtu_yy_xx_flush;
    logic       wmb_cq_push_vld;
    logic [6:0] wmb_cq_push_iid;
    logic       wmb_cq_push_inst_flush;
    logic       wmb_cq_push_spec_fail;
    logic       wmb_cq_push_bkpta_data;
    logic       wmb_cq_push_bkptb_data;
    logic       cq_wmb_full;
    logic       cq_wmb_empty;
    logic       wmb_st_wb_cmplt_req;
    logic [6:0] wmb_st_wb_iid;
    logic       wmb_st_wb_inst_flush;
    logic       wmb_st_wb_spec_fail;
    logic       wmb_st_wb_bkpta_data;
    logic       wmb_st_wb_bkptb_data;
    logic       st_wb_wmb_cmplt_grnt;

    int checks   = 0;
    int failures = 0;

    ct_lsu_wmb_cmplt_queue dut (
        .ctrl_st_clk            (ctrl_st_clk),
        .cpurst_b               (cpurst_b),
        .rtu_yy_xx_flush        (rtu_yy_xx_flush),
        .wmb_cq_push_vld        (wmb_cq_push_vld),
        .wmb_cq_push_iid        (wmb_cq_push_iid),
        .wmb_cq_push_inst_flush (wmb_cq_push_inst_flush),
        .wmb_cq_push_spec_fail  (wmb_cq_push_spec_fail),
        .wmb_cq_push_bkpta_data (wmb_cq_push_bkpta_data),
        .wmb_cq_push_bkptb_data (wmb_cq_push_bkptb_data),
        .cq_wmb_full            (cq_wmb_full),
        .cq_wmb_empty           (cq_wmb_empty),
        .wmb_st_wb_cmplt_req    (wmb_st_wb_cmplt_req),
        .wmb_st_wb_iid          (wmb_st_wb_iid),
        .wmb_st_wb_inst_flush   (wmb_st_wb_inst_flush),
        .wmb_st_wb_spec_fail    (wmb_st_wb_spec_fail),
        .wmb_st_wb_bkpta_data   (wmb_st_wb_bkpta_data),
        .wmb_st_wb_bkptb_data   (wmb_st_wb_bkptb_data),
        .st_wb_wmb_cmplt_grnt   (st_wb_wmb_cmplt_grnt)
    );

    initial ctrl_st_clk = 1'b0;
    always #5 ctrl_st_clk = ~ctrl_st_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
    task automatic tick;
        @(posedge ctrl_st_clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [6:0] iid, input logic [3:0] flags,
                         input logic grnt, input logic flush);
        wmb_cq_push_vld        = vld;
        wmb_cq_push_iid        = iid;
        wmb_cq_push_inst_flush = flags[3];
        wmb_cq_push_spec_fail  = flags[2];
        wmb_cq_push_bkpta_data = flags[1];
        wmb_cq_push_bkptb_data = flags[0];
        st_wb_wmb_cmplt_grnt   = grnt;
        rtu_yy_xx_flush        = flush;
        #1;
    endtask

    task automatic test_reset;
        cpurst_b = 1'b0;
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (cq_wmb_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", cq_wmb_empty); end
        checks++;
        if (cq_wmb_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", cq_wmb_full); end
        checks++;
        if (wmb_st_wb_cmplt_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", wmb_st_wb_cmplt_req); end
        checks++;
        if ({wmb_st_wb_iid, wmb_st_wb_inst_flush, wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data} !== 11'd0) begin
            failures++; $display("[TB] FAIL reset_head got=%h exp=0", wmb_st_wb_iid);
        end
        tick();
        cpurst_b = 1'b1;
        tick();
    endtask

    task automatic test_single_push;
        drive(1'b1, 7'h05, 4'b1010, 1'b0, 1'b0);
`ifdef CT_LSU_WMB_CQ_BYPASS_EN
        checks++;
        if (wmb_st_wb_cmplt_req !== 1'b1) begin failures++; $display("[TB] FAIL single_bypass_req got=%b exp=1", wmb_st_wb_cmplt_req); end
`else
        checks++;
        if (wmb_st_wb_cmplt_req !== 1'b0) begin failures++; $display("[TB] FAIL single_push_cycle_req got=%b exp=0", wmb_st_wb_cmplt_req); end
`endif
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wmb_st_wb_cmplt_req !== 1'b1 || wmb_st_wb_iid !== 7'h05) begin
                failures++; $display("[TB] FAIL single_hold cycle=%0d req=%b iid=%h exp req=1 iid=05", c, wmb_st_wb_cmplt_req, wmb_st_wb_iid);
            end
            checks++;
            if ({wmb_st_wb_inst_flush, wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data} !== 4'b1010) begin
                failures++; $display("[TB] FAIL single_flags cycle=%0d got=%b%b%b%b exp=1010", c, wmb_st_wb_inst_flush,
                                     wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data);
            end
            tick();
        end
        drive(1'b0, 7'h00, 4'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_empty !== 1'b1 || wmb_st_wb_cmplt_req !== 1'b0) begin
            failures++; $display("[TB] FAIL single_pop empty=%b req=%b exp empty=1 req=0", cq_wmb_empty, wmb_st_wb_cmplt_req);
        end
    endtask

    task automatic test_empty_grant;
        drive(1'b0, 7'h00, 4'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 7'h77, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (wmb_st_wb_cmplt_req !== 1'b1 || wmb_st_wb_iid !== 7'h77 || cq_wmb_empty !== 1'b0) begin
            failures++; $display("[TB] FAIL empty_grant req=%b iid=%h empty=%b exp req=1 iid=77 empty=0",
                                 wmb_st_wb_cmplt_req, wmb_st_wb_iid, cq_wmb_empty);
        end
        drive(1'b0, 7'h00, 4'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_full;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 7'h10 + 7'(k), 4'(k), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_full !== 1'b1) begin failures++; $display("[TB] FAIL full_flag got=%b exp=1", cq_wmb_full); end
        drive(1'b1, 7'h14, 4'hF, 1'b0, 1'b0);
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_full !== 1'b1 || wmb_st_wb_iid !== 7'h10) begin
            failures++; $display("[TB] FAIL full_drop full=%b iid=%h exp full=1 iid=10", cq_wmb_full, wmb_st_wb_iid);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 7'h00, 4'h0, 1'b1, 1'b0);
            checks++;
            if (wmb_st_wb_cmplt_req !== 1'b1 || wmb_st_wb_iid !== 7'h10 + 7'(k)) begin
                failures++; $display("[TB] FAIL full_pop k=%0d req=%b iid=%h exp req=1 iid=%h", k, wmb_st_wb_cmplt_req, wmb_st_wb_iid, 7'h10 + 7'(k));
            end
            checks++;
            if ({wmb_st_wb_inst_flush, wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data} !== 4'(k)) begin
                failures++; $display("[TB] FAIL full_pop_flags k=%0d got=%b%b%b%b exp=%b", k, wmb_st_wb_inst_flush,
                                     wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data, 4'(k));
            end
            tick();
        end
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_empty !== 1'b1) begin failures++; $display("[TB] FAIL full_drain_empty got=%b exp=1", cq_wmb_empty); end
    endtask

    task automatic test_full_pop_push;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 7'h58 + 7'(k), 4'h0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 7'h5C, 4'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_full !== 1'b0 || wmb_st_wb_iid !== 7'h59) begin
            failures++; $display("[TB] FAIL full_pop_push full=%b iid=%h exp full=0 iid=59", cq_wmb_full, wmb_st_wb_iid);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 7'h00, 4'h0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_empty !== 1'b1) begin failures++; $display("[TB] FAIL full_pop_push_drop empty=%b exp=1", cq_wmb_empty); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 7'h50, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'h51, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'h52, 4'h0, 1'b1, 1'b0);
        checks++;
        if (wmb_st_wb_iid !== 7'h50) begin failures++; $display("[TB] FAIL b2b_head0 got=%h exp=50", wmb_st_wb_iid); end
        tick();
        for (int k = 1; k < 3; k++) begin
            drive(1'b0, 7'h00, 4'h0, 1'b1, 1'b0);
            checks++;
            if (wmb_st_wb_cmplt_req !== 1'b1 || wmb_st_wb_iid !== 7'h50 + 7'(k)) begin
                failures++; $display("[TB] FAIL b2b_order k=%0d req=%b iid=%h exp req=1 iid=%h", k, wmb_st_wb_cmplt_req, wmb_st_wb_iid, 7'h50 + 7'(k));
            end
            tick();
        end
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_empty !== 1'b1) begin failures++; $display("[TB] FAIL b2b_occupancy empty=%b exp=1", cq_wmb_empty); end
    endtask

    task automatic test_flush;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 7'h60 + 7'(k), 4'h0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 7'h20, 4'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (cq_wmb_empty !== 1'b1 || wmb_st_wb_cmplt_req !== 1'b0) begin
                failures++; $display("[TB] FAIL flush_empty cycle=%0d empty=%b req=%b iid=%h exp empty=1 req=0",
                                     c, cq_wmb_empty, wmb_st_wb_cmplt_req, wmb_st_wb_iid);
            end
            tick();
        end
    endtask

    task automatic test_wrap;
        drive(1'b1, 7'h30, 4'h0, 1'b0, 1'b0);
        tick();
        for (int k = 1; k < 13; k++) begin
            drive(k < 12, 7'h30 + 7'(k), 4'h0, 1'b1, 1'b0);
            checks++;
            if (wmb_st_wb_cmplt_req !== 1'b1 || wmb_st_wb_iid !== 7'h30 + 7'(k - 1)) begin
                failures++; $display("[TB] FAIL wrap_order k=%0d req=%b iid=%h exp req=1 iid=%h", k, wmb_st_wb_cmplt_req, wmb_st_wb_iid, 7'h30 + 7'(k - 1));
            end
            tick();
        end
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_empty !== 1'b1) begin failures++; $display("[TB] FAIL wrap_empty got=%b exp=1", cq_wmb_empty); end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 7'h66, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        #1;
        cpurst_b = 1'b0;
        #1;
        checks++;
        if (cq_wmb_empty !== 1'b1 || wmb_st_wb_cmplt_req !== 1'b0 || wmb_st_wb_iid !== 7'h00) begin
            failures++; $display("[TB] FAIL async_reset empty=%b req=%b iid=%h exp empty=1 req=0 iid=00",
                                 cq_wmb_empty, wmb_st_wb_cmplt_req, wmb_st_wb_iid);
        end
        tick();
        cpurst_b = 1'b1;
        tick();
    endtask

`ifdef CT_LSU_WMB_CQ_BYPASS_EN
    task automatic test_bypass;
        drive(1'b1, 7'h41, 4'b0101, 1'b1, 1'b0);
        checks++;
        if (wmb_st_wb_cmplt_req !== 1'b1 || wmb_st_wb_iid !== 7'h41 || wmb_st_wb_bkptb_data !== 1'b1) begin
            failures++; $display("[TB] FAIL bypass_same_cycle req=%b iid=%h bkptb=%b exp req=1 iid=41 bkptb=1",
                                 wmb_st_wb_cmplt_req, wmb_st_wb_iid, wmb_st_wb_bkptb_data);
        end
        tick();
        drive(1'b0, 7'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (cq_wmb_empty !== 1'b1 || wmb_st_wb_cmplt_req !== 1'b0) begin
            failures++; $display("[TB] FAIL bypass_empty empty=%b req=%b exp empty=1 req=0", cq_wmb_empty, wmb_st_wb_cmplt_req);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_push();
        test_empty_grant();
        test_full();
        test_full_pop_push();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_async_reset();
`ifdef CT_LSU_WMB_CQ_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
